// File: rtl/timebase_gen_pkg.sv
// Shared constants and width helpers for the timebase generator.
// The divider chain and its interface both derive counter widths from here.
package timebase_pkg;

    localparam int CLK_FREQ_DEF  = 50_000_000;
    localparam int US_PER_MS_DEF = 1000;
    localparam int MS_PER_S_DEF  = 1000;

    function automatic int clks_per_us(input int clk_freq_hz);
        return clk_freq_hz / 1_000_000;
    endfunction

    // A modulo-1 counter would need zero bits; keep at least one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timebase_gen_if.sv
// Control inputs and tick/count outputs of the timebase generator.
// master = the generator, slave = a consumer such as the PWM stage.
interface timebase_gen_if
    import timebase_pkg::*;
#(
    parameter int US_PER_MS = US_PER_MS_DEF,
    parameter int MS_PER_S  = MS_PER_S_DEF
) ();

    localparam int US_W = cnt_w(US_PER_MS);
    localparam int MS_W = cnt_w(MS_PER_S);

    logic            run;
    logic            sync_clr;
    logic            tick_1us;
    logic            tick_1ms;
    logic            tick_1s;
    logic [US_W-1:0] cnt_us;
    logic [MS_W-1:0] cnt_ms;
    logic            phase_1s;

    modport master (
        input  run, sync_clr,
        output tick_1us, tick_1ms, tick_1s, cnt_us, cnt_ms, phase_1s
    );

    modport slave (
        output run, sync_clr,
        input  tick_1us, tick_1ms, tick_1s, cnt_us, cnt_ms, phase_1s
    );

endinterface

// File: rtl/timebase_gen_mod_cnt.sv
// Modulo-N counter with synchronous clear; wrap flags the increment that
// takes the count from N-1 back to 0, so stages can be cascaded on it.
module tb_mod_cnt
    import timebase_pkg::*;
#(
    parameter int N = 2,
    parameter int W = cnt_w(N)
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = inc && (cnt == W'(N - 1));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (clr || wrap) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timebase_gen.sv
// 1 us / 1 ms / 1 s enable-tick generator on sys_clk: a cascade of three
// modulo counters whose wrap strobes are registered into the tick outputs.
module timebase_gen
    import timebase_pkg::*;
#(
    parameter int CLK_FREQ_HZ = CLK_FREQ_DEF,
    parameter int US_PER_MS   = US_PER_MS_DEF,
    parameter int MS_PER_S    = MS_PER_S_DEF
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    timebase_gen_if.master bus
);

    localparam int CLKS_PER_US = clks_per_us(CLK_FREQ_HZ);
    localparam int PRE_W       = cnt_w(CLKS_PER_US);
    localparam int US_W        = cnt_w(US_PER_MS);
    localparam int MS_W        = cnt_w(MS_PER_S);

    if ((CLK_FREQ_HZ % 1_000_000) != 0 || CLK_FREQ_HZ < 2_000_000) begin : g_bad_clk
        $error("timebase_gen: CLK_FREQ_HZ=%0d must be a multiple of 1e6 and >= 2e6", CLK_FREQ_HZ);
    end
    if (US_PER_MS < 2) begin : g_bad_us
        $error("timebase_gen: US_PER_MS=%0d must be >= 2", US_PER_MS);
    end
    if (MS_PER_S < 2) begin : g_bad_ms
        $error("timebase_gen: MS_PER_S=%0d must be >= 2", MS_PER_S);
    end

    logic [PRE_W-1:0] pre_cnt;
    logic [US_W-1:0]  us_cnt;
    logic [MS_W-1:0]  ms_cnt;
    logic             pre_wrap, us_wrap, ms_wrap;
    logic             tick_us_q, tick_ms_q, tick_s_q, phase_q;

    tb_mod_cnt #(.N(CLKS_PER_US)) u_pre (
        .sys_clk, .sys_rst_n,
        .clr(bus.sync_clr), .inc(bus.run),
        .cnt(pre_cnt), .wrap(pre_wrap)
    );

    tb_mod_cnt #(.N(US_PER_MS)) u_us (
        .sys_clk, .sys_rst_n,
        .clr(bus.sync_clr), .inc(pre_wrap),
        .cnt(us_cnt), .wrap(us_wrap)
    );

    tb_mod_cnt #(.N(MS_PER_S)) u_ms (
        .sys_clk, .sys_rst_n,
        .clr(bus.sync_clr), .inc(us_wrap),
        .cnt(ms_cnt), .wrap(ms_wrap)
    );

    // Wrap strobes are still raised while sync_clr is high, so gate them here.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tick_us_q <= 1'b0;
            tick_ms_q <= 1'b0;
            tick_s_q  <= 1'b0;
            phase_q   <= 1'b0;
        end else if (bus.sync_clr) begin
            tick_us_q <= 1'b0;
            tick_ms_q <= 1'b0;
            tick_s_q  <= 1'b0;
        end else begin
            tick_us_q <= pre_wrap;
            tick_ms_q <= us_wrap;
            tick_s_q  <= ms_wrap;
            if (ms_wrap) phase_q <= ~phase_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) assert (int'(pre_cnt) < CLKS_PER_US);
    end

    assign bus.tick_1us = tick_us_q;
    assign bus.tick_1ms = tick_ms_q;
    assign bus.tick_1s  = tick_s_q;
    assign bus.cnt_us   = us_cnt;
    assign bus.cnt_ms   = ms_cnt;
    assign bus.phase_1s = phase_q;

endmodule

// File: tb/tb_timebase_gen.sv
// Bench for timebase_gen at 4 MHz / 5 us per ms / 3 ms per s: directed
// vector table, scenario sequences and a random run against an elapsed-time model.
module tb_timebase_gen;

    localparam int CPU = 4;
    localparam int UPM = 5;
    localparam int MPS = 3;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    int   total  = 0;
    int   passed = 0;

    timebase_gen_if #(.US_PER_MS(UPM), .MS_PER_S(MPS)) bus ();

    timebase_gen #(.CLK_FREQ_HZ(4_000_000), .US_PER_MS(UPM), .MS_PER_S(MPS)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Model state: running edges since the last reset/clear, and seconds parity.
    int n   = 0;
    bit ph  = 1'b0;
    bit e_us, e_ms, e_s;

    typedef struct {
        bit rst_n, clr, run;
        bit tus, tms, ts;
        int cus, cms;
        bit ph;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic step(input bit r, input bit c, input bit u);
        sys_rst_n    = r;
        bus.sync_clr = c;
        bus.run      = u;
        @(posedge sys_clk);
        e_us = 0; e_ms = 0; e_s = 0;
        if (!r) begin
            n = 0; ph = 0;
        end else if (c) begin
            n = 0;
        end else if (u) begin
            n++;
            e_us = (n % CPU) == 0;
            e_ms = (n % (CPU * UPM)) == 0;
            e_s  = (n % (CPU * UPM * MPS)) == 0;
            if (e_s) ph = ~ph;
        end
        @(negedge sys_clk);
        chk("tick_1us", int'(bus.tick_1us), int'(e_us));
        chk("tick_1ms", int'(bus.tick_1ms), int'(e_ms));
        chk("tick_1s",  int'(bus.tick_1s),  int'(e_s));
        chk("cnt_us",   int'(bus.cnt_us),   (n / CPU) % UPM);
        chk("cnt_ms",   int'(bus.cnt_ms),   (n / (CPU * UPM)) % MPS);
        chk("phase_1s", int'(bus.phase_1s), int'(ph));
    endtask

    task automatic do_reset();
        step(0, 0, 1);
        step(0, 0, 1);
    endtask

    // Assumes reset has just been released; checks the free-run timing.
    task automatic freerun();
        int k_us = 0, k_ms = 0, k_s = 0;
        for (int c = 1; c <= 130; c++) begin
            step(1, 0, 1);
            if (bus.tick_1us) begin
                k_us++;
                chk("fr_cnt_us_at_tick", int'(bus.cnt_us), k_us % UPM);
                chk("fr_cnt_ms_at_tick", int'(bus.cnt_ms), (k_us / UPM) % MPS);
            end
            if (bus.tick_1ms) k_ms++;
            if (bus.tick_1s) begin
                k_s++;
                chk("fr_s_cycle", c, 60 * k_s);
                chk("fr_s_coinc", int'({bus.tick_1s, bus.tick_1ms, bus.tick_1us}), 7);
            end
            if (c == 4)   chk("fr_first_us", int'(bus.tick_1us), 1);
            if (c == 20)  chk("fr_first_ms", int'(bus.tick_1ms), 1);
            if (c == 61)  chk("fr_phase_after60", int'(bus.phase_1s), 1);
            if (c == 121) chk("fr_phase_after120", int'(bus.phase_1s), 0);
        end
        chk("fr_n_us", k_us, 32);
        chk("fr_n_ms", k_ms, 6);
        chk("fr_n_s",  k_s, 2);
    endtask

    initial begin
        vec_t vecs[15];
        int   first_us, first_ms, paused;
        bit   ph_before;

        vecs[0]  = '{0,0,1, 0,0,0, 0,0,0};
        vecs[1]  = '{1,0,1, 0,0,0, 0,0,0};
        vecs[2]  = '{1,0,1, 0,0,0, 0,0,0};
        vecs[3]  = '{1,0,1, 0,0,0, 0,0,0};
        vecs[4]  = '{1,0,1, 1,0,0, 1,0,0};
        vecs[5]  = '{1,0,0, 0,0,0, 1,0,0};
        vecs[6]  = '{1,0,1, 0,0,0, 1,0,0};
        vecs[7]  = '{1,0,1, 0,0,0, 1,0,0};
        vecs[8]  = '{1,0,1, 0,0,0, 1,0,0};
        vecs[9]  = '{1,1,0, 0,0,0, 0,0,0};
        vecs[10] = '{1,0,1, 0,0,0, 0,0,0};
        vecs[11] = '{1,0,1, 0,0,0, 0,0,0};
        vecs[12] = '{1,0,1, 0,0,0, 0,0,0};
        vecs[13] = '{1,0,1, 1,0,0, 1,0,0};
        vecs[14] = '{0,1,1, 0,0,0, 0,0,0};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst_n, vecs[i].clr, vecs[i].run);
            chk($sformatf("vec%0d_tus", i), int'(bus.tick_1us), int'(vecs[i].tus));
            chk($sformatf("vec%0d_tms", i), int'(bus.tick_1ms), int'(vecs[i].tms));
            chk($sformatf("vec%0d_ts",  i), int'(bus.tick_1s),  int'(vecs[i].ts));
            chk($sformatf("vec%0d_cus", i), int'(bus.cnt_us),   vecs[i].cus);
            chk($sformatf("vec%0d_cms", i), int'(bus.cnt_ms),   vecs[i].cms);
            chk($sformatf("vec%0d_ph",  i), int'(bus.phase_1s), int'(vecs[i].ph));
        end

        // Free run from reset.
        do_reset();
        freerun();

        // Pause for 7 edges starting at cycle 10.
        do_reset();
        first_us = 0; first_ms = 0; paused = 0;
        for (int c = 1; c <= 30; c++) begin
            step(1, 0, !(c >= 10 && c <= 16));
            if (c >= 10 && c <= 16) paused += int'(bus.tick_1us) + int'(bus.tick_1ms);
            if (c > 9 && bus.tick_1us && first_us == 0) first_us = c;
            if (bus.tick_1ms && first_ms == 0) first_ms = c;
        end
        chk("pause_no_ticks", paused, 0);
        chk("pause_next_us", first_us, 19);
        chk("pause_next_ms", first_ms, 27);

        // sync_clr at 33 (phase 0) and at 97 (phase 1, after a second at 93).
        do_reset();
        ph_before = 0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 33 || c == 97) ph_before = bus.phase_1s;
            step(1, (c == 33 || c == 97), 1);
            if (c == 33 || c == 97) begin
                chk("clr_cnts", int'(bus.cnt_us) + int'(bus.cnt_ms), 0);
                chk("clr_ticks", int'({bus.tick_1s, bus.tick_1ms, bus.tick_1us}), 0);
                chk("clr_phase_hold", int'(bus.phase_1s), int'(ph_before));
            end
            if (c == 36) chk("clr_no_early_us", int'(bus.tick_1us), 0);
            if (c == 37) chk("clr_next_us", int'(bus.tick_1us), 1);
            if (c == 96) chk("clr_phase_set", int'(bus.phase_1s), 1);
        end

        // Reset (with sync_clr) at cycle 61 after phase went high, then free run.
        do_reset();
        for (int c = 1; c <= 60; c++) step(1, 0, 1);
        chk("rst_pre_phase", int'(bus.phase_1s), 1);
        step(0, 1, 1);
        chk("rst_phase", int'(bus.phase_1s), 0);
        chk("rst_cnts", int'(bus.cnt_us) + int'(bus.cnt_ms), 0);
        step(0, 1, 0);
        freerun();

        // Random control against the model.
        do_reset();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(63) != 0, $urandom_range(31) == 0, $urandom_range(3) != 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
